load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/lsu_align.sv | 59 +++++
 rtl/load_store_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: FSM state type, funct3
// size/sign encodings and the fault classification helper.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access never reaches memory: unknown size encoding, a store with an
    // unsigned size, or an address not aligned to the access size.
    function automatic logic lsu_fault(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                     (we && (funct3 > F3_W));
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replicated write data, and
// load lane extraction with sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Store side: enables follow size and offset; data is replicated so
    // every lane carries the operand and only the enables pick the target.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend to 32 bits.
    always_comb begin
        rbyte     = 8'h00;
        rhalf     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = rdata;
        case (addr_lo)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        case (funct3)
            F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rdata_ext = {24'h000000, rbyte};
            F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rdata_ext = {16'h0000, rhalf};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between EX and a valid/ready memory port.
//
// state  | meaning
// S_IDLE | ready for a new operation; captures req_* on req_valid
// S_REQ  | mem_valid held with stable mem_* until mem_ready
// S_WAIT | load issued; waiting for mem_rvalid
// S_RESP | one-cycle completion pulse on rsp_valid
module load_store_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    lsu_state_t  state;
    lsu_state_t  state_nxt;
    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [4:0]  cap_rd;
    logic [31:0] data_q;
    logic        err_q;
    logic [31:0] load_ext;
    logic        accept;

    assign accept = (state == S_IDLE) && req_valid;

    lsu_align u_align (
        .funct3     (cap_funct3),
        .addr_lo    (cap_addr[1:0]),
        .wdata      (cap_wdata),
        .rdata      (mem_rdata),
        .be         (mem_be),
        .wdata_lane (mem_wdata),
        .rdata_ext  (load_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Operation capture and response data; data_q is cleared on accept so
    // stores and faults complete with zero data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cap_we     <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
            cap_rd     <= 5'd0;
            data_q     <= 32'h0;
            err_q      <= 1'b0;
        end else if (accept) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_rd     <= req_rd;
            data_q     <= 32'h0;
            err_q      <= lsu_fault(req_we, req_funct3, req_addr[1:0]);
        end else if ((state == S_WAIT) && mem_rvalid) begin
            data_q     <= load_ext;
        end
    end

    // Next-state logic and state-decoded handshakes.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_valid = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = reset_n;
                if (req_valid)
                    state_nxt = lsu_fault(req_we, req_funct3, req_addr[1:0]) ? S_RESP : S_REQ;
            end
            S_REQ: begin
                mem_valid = 1'b1;
                if (mem_ready) state_nxt = cap_we ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mem_addr = {cap_addr[31:2], 2'b00};
    assign mem_we   = cap_we;
    assign rsp_rd   = cap_rd;
    assign rsp_data = data_q;
    assign rsp_err  = err_q && (state == S_RESP);

endmodule
